// File: rtl/downsizing_n_if.sv
// Bundle of stream signals for the downsizing_n width converter.
// Wide input stream (in_*) and narrow output stream (out_*).
//   master : upstream producer / downstream consumer view (drives in_*, out_tready)
//   slave  : downsizer view (consumes in_*, drives in_tready and out_*)
interface downsizing_n_if #(
  parameter int W     = 32,
  parameter int RATIO = 4,
  parameter int CW    = $clog2(RATIO + 1)
);
  logic [W*RATIO-1:0] in_tdata;
  logic [CW-1:0]      in_tcount;
  logic               in_tlast;
  logic               in_tvalid;
  logic               in_tready;
  logic [W-1:0]       out_tdata;
  logic               out_tlast;
  logic               out_tvalid;
  logic               out_tready;

  modport master (
    output in_tdata, in_tcount, in_tlast, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tlast, out_tvalid
  );

  modport slave (
    input  in_tdata, in_tcount, in_tlast, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tlast, out_tvalid
  );
endinterface

// File: rtl/downsizing_n.sv
// Parametrised AXI-Stream width downsizer: one W*RATIO-bit input beat is split
// into up to RATIO W-bit output words, with partial beats (in_tcount), tlast
// propagation and zero-bubble back-to-back operation.
// Ports:
//   aclk    : clock, rising edge
//   areset  : synchronous reset, active-high
//   bus     : downsizing_n_if.slave (in_tdata/in_tcount/in_tlast/in_tvalid/in_tready,
//             out_tdata/out_tlast/out_tvalid/out_tready)
module downsizing_n #(
  parameter int W         = 32,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic            aclk,
  input  logic            areset,
  downsizing_n_if.slave   bus
);
  localparam int CW = $clog2(RATIO + 1);
  localparam int IW = $clog2(RATIO);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W*RATIO-1:0] r_buf;
  logic [W*RATIO-1:0] w_buf_nxt;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [CW-1:0]      w_cnt_in;
  logic               r_last;
  logic               w_last_nxt;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      w_idx_nxt;
  logic [IW-1:0]      w_pos;
  logic               w_full;
  logic               w_at_end;
  logic               w_in_ready;
  logic               w_load;

  assign w_full = (r_state == ST_BUSY);

  // Effective word count of the incoming beat: 0 or out-of-range means a full beat
  always_comb begin
    w_cnt_in = CW'(RATIO);
    if ((bus.in_tcount == {CW{1'b0}}) || (bus.in_tcount > CW'(RATIO))) begin
      w_cnt_in = CW'(RATIO);
    end else begin
      w_cnt_in = bus.in_tcount;
    end
  end

  // The word on the output is the last valid word of the held beat
  assign w_at_end   = (CW'(r_idx) == (r_cnt - CW'(1)));
  // Ready when empty, or when the final word leaves this cycle (no bubble)
  assign w_in_ready = ~w_full | (bus.out_tready & w_at_end);
  assign w_load     = bus.in_tvalid & w_in_ready;

  // Next-state logic of the EMPTY/BUSY controller
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (bus.in_tvalid) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_BUSY: begin
        if (bus.out_tready & w_at_end & ~bus.in_tvalid) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Datapath next values: capture a beat, advance the word index, or hold (stall)
  always_comb begin
    w_buf_nxt  = r_buf;
    w_cnt_nxt  = r_cnt;
    w_last_nxt = r_last;
    w_idx_nxt  = r_idx;
    if (w_load) begin
      w_buf_nxt  = bus.in_tdata;
      w_cnt_nxt  = w_cnt_in;
      w_last_nxt = bus.in_tlast;
      w_idx_nxt  = {IW{1'b0}};
    end else if (w_full & bus.out_tready & ~w_at_end) begin
      w_idx_nxt  = r_idx + IW'(1);
    end else begin
      w_idx_nxt  = r_idx;
    end
  end

  // State and datapath registers; reset drops any partially emitted beat
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_EMPTY;
      r_buf   <= {(W*RATIO){1'b0}};
      r_cnt   <= CW'(RATIO);
      r_last  <= 1'b0;
      r_idx   <= {IW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Word slot inside the buffer: index counts from the top when MSB_FIRST
  assign w_pos = (MSB_FIRST != 0) ? (IW'(RATIO - 1) - r_idx) : r_idx;

  assign bus.out_tdata  = r_buf[int'(w_pos)*W +: W];
  assign bus.out_tvalid = w_full;
  assign bus.out_tlast  = w_full & r_last & w_at_end;
  assign bus.in_tready  = w_in_ready;
endmodule

// File: tb/tb_downsizing_n.sv
// Self-checking bench for downsizing_n (W=8, RATIO=4). Two instances run in
// lockstep, one MSB-first and one LSB-first, against a queue-based word model.
module tb_downsizing_n;
  logic        aclk = 1'b0;
  logic        areset;
  logic        tb_v;
  logic        tb_l;
  logic        tb_rdy;
  logic [31:0] tb_d;
  logic [2:0]  tb_c;

  int checks = 0;
  int errors = 0;

  logic [8:0]  qm[$];
  logic [8:0]  ql[$];
  logic [10:0] exp_m, exp_l, obs_m, obs_l;
  logic        exp_ready;
  logic [7:0]  obs_dm, obs_dl;
  logic        obs_lm;

  always #5 aclk = ~aclk;

  downsizing_n_if #(.W(8), .RATIO(4)) if_m ();
  downsizing_n_if #(.W(8), .RATIO(4)) if_l ();

  assign if_m.in_tdata   = tb_d;
  assign if_m.in_tcount  = tb_c;
  assign if_m.in_tlast   = tb_l;
  assign if_m.in_tvalid  = tb_v;
  assign if_m.out_tready = tb_rdy;
  assign if_l.in_tdata   = tb_d;
  assign if_l.in_tcount  = tb_c;
  assign if_l.in_tlast   = tb_l;
  assign if_l.in_tvalid  = tb_v;
  assign if_l.out_tready = tb_rdy;

  downsizing_n #(.W(8), .RATIO(4), .MSB_FIRST(1)) u_msb (.aclk(aclk), .areset(areset), .bus(if_m));
  downsizing_n #(.W(8), .RATIO(4), .MSB_FIRST(0)) u_lsb (.aclk(aclk), .areset(areset), .bus(if_l));

  // One clock cycle: apply inputs, record model expectation and DUT observation,
  // then advance the model by the handshakes the specification predicts.
  task automatic cycle(input logic rst, input logic v, input logic [31:0] d,
                       input logic [2:0] c, input logic l, input logic rdy);
    int n;
    logic ev;
    areset = rst; tb_v = v; tb_d = d; tb_c = c; tb_l = l; tb_rdy = rdy;
    #1;
    ev        = (qm.size() != 0);
    exp_ready = (qm.size() == 0) || (rdy && qm.size() == 1);
    exp_m = {ev, exp_ready, ev ? qm[0] : 9'h000};
    exp_l = {ev, exp_ready, ev ? ql[0] : 9'h000};
    obs_m = {if_m.out_tvalid, if_m.in_tready,
             if_m.out_tvalid ? if_m.out_tdata : 8'h00, if_m.out_tlast};
    obs_l = {if_l.out_tvalid, if_l.in_tready,
             if_l.out_tvalid ? if_l.out_tdata : 8'h00, if_l.out_tlast};
    obs_dm = if_m.out_tdata;
    obs_dl = if_l.out_tdata;
    obs_lm = if_m.out_tlast;
    if (rst) begin
      qm.delete();
      ql.delete();
    end else begin
      if (ev && rdy) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (v && exp_ready) begin
        n = (c == 3'd0 || c > 3'd4) ? 4 : int'(c);
        for (int k = 0; k < n; k++) begin
          qm.push_back({d[(3-k)*8 +: 8], l && (k == n-1)});
          ql.push_back({d[k*8 +: 8],     l && (k == n-1)});
        end
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    if (obs_m !== exp_m) begin errors++; $display("FAIL reset msb got %h want %h", obs_m, exp_m); end
    if (obs_l !== exp_l) begin errors++; $display("FAIL reset lsb got %h want %h", obs_l, exp_l); end
    if ({obs_dm, obs_dl} !== 16'h0000) begin
      errors++; $display("FAIL reset_tdata got %h want 0000", {obs_dm, obs_dl});
    end
    checks += 3;
  endtask

  task automatic test_full_beat();
    logic [7:0] tbl [4];
    tbl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, i == 0, 32'hAABBCCDD, 3'd4, 1'b1, 1'b1);
      if (obs_m !== exp_m) begin errors++; $display("FAIL full_beat msb cyc %0d got %h want %h", i, obs_m, exp_m); end
      if (obs_l !== exp_l) begin errors++; $display("FAIL full_beat lsb cyc %0d got %h want %h", i, obs_l, exp_l); end
      checks += 2;
      if (i >= 1 && i <= 4) begin
        if ({obs_dm, obs_dl, obs_lm} !== {tbl[i-1], tbl[4-i], i == 4}) begin
          errors++;
          $display("FAIL full_beat_tbl cyc %0d got %h %h %b want %h %h %b",
                   i, obs_dm, obs_dl, obs_lm, tbl[i-1], tbl[4-i], i == 4);
        end
        checks++;
      end
    end
  endtask

  task automatic test_cnt_zero();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, i == 0, 32'hAABBCCDD, 3'd0, 1'b1, 1'b1);
      if (obs_m !== exp_m) begin errors++; $display("FAIL cnt_zero msb cyc %0d got %h want %h", i, obs_m, exp_m); end
      if (obs_l !== exp_l) begin errors++; $display("FAIL cnt_zero lsb cyc %0d got %h want %h", i, obs_l, exp_l); end
      checks += 2;
    end
  endtask

  task automatic test_partial();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, i == 0, 32'h11223344, 3'd2, 1'b1, 1'b1);
      if (obs_m !== exp_m) begin errors++; $display("FAIL partial msb cyc %0d got %h want %h", i, obs_m, exp_m); end
      if (obs_l !== exp_l) begin errors++; $display("FAIL partial lsb cyc %0d got %h want %h", i, obs_l, exp_l); end
      checks += 2;
    end
    if ({if_m.out_tvalid, if_m.in_tready} !== 2'b01) begin
      errors++; $display("FAIL partial_empty got %b want 01", {if_m.out_tvalid, if_m.in_tready});
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] beats [2];
    int nb = 0;
    int nvalid = 0;
    int nready = 0;
    beats = '{32'h01020304, 32'h05060708};
    for (int i = 0; i < 11; i++) begin
      cycle(1'b0, nb < 2, beats[nb < 2 ? nb : 1], 3'd4, 1'b0, 1'b1);
      if (nb < 2 && exp_ready) nb++;
      if (obs_m !== exp_m) begin errors++; $display("FAIL b2b msb cyc %0d got %h want %h", i, obs_m, exp_m); end
      if (obs_l !== exp_l) begin errors++; $display("FAIL b2b lsb cyc %0d got %h want %h", i, obs_l, exp_l); end
      checks += 2;
      if (i >= 1 && i <= 8) begin
        nvalid += int'(obs_m[10]);
        nready += int'(obs_m[9]);
      end
    end
    if (nvalid != 8 || nready != 2) begin
      errors++; $display("FAIL b2b_counts got valid=%0d ready=%0d want valid=8 ready=2", nvalid, nready);
    end
    checks++;
  endtask

  task automatic test_random_stall();
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), (i % 4 == 0 || i % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1)));
      if (obs_m !== exp_m) begin errors++; $display("FAIL random msb cyc %0d got %h want %h", i, obs_m, exp_m); end
      if (obs_l !== exp_l) begin errors++; $display("FAIL random lsb cyc %0d got %h want %h", i, obs_l, exp_l); end
      checks += 2;
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
      if (obs_m !== exp_m) begin errors++; $display("FAIL drain msb cyc %0d got %h want %h", i, obs_m, exp_m); end
      if (obs_l !== exp_l) begin errors++; $display("FAIL drain lsb cyc %0d got %h want %h", i, obs_l, exp_l); end
      checks += 2;
    end
  endtask

  task automatic test_reset_mid_beat();
    for (int i = 0; i < 10; i++) begin
      cycle(i == 3, i == 0 || i == 4, (i == 0) ? 32'hA1B2C3D4 : 32'h5E6F7081,
            3'd4, 1'b1, i != 3);
      if (obs_m !== exp_m) begin errors++; $display("FAIL rst_mid msb cyc %0d got %h want %h", i, obs_m, exp_m); end
      if (obs_l !== exp_l) begin errors++; $display("FAIL rst_mid lsb cyc %0d got %h want %h", i, obs_l, exp_l); end
      checks += 2;
      if (i == 4 && obs_m[10] !== 1'b0) begin
        errors++; $display("FAIL rst_mid_valid got %b want 0", obs_m[10]);
      end
      if (i == 4) checks++;
    end
  endtask

  initial begin
    areset = 1'b1; tb_v = 1'b0; tb_d = 32'h0; tb_c = 3'd0; tb_l = 1'b0; tb_rdy = 1'b0;
    @(posedge aclk);
    #1;
    test_reset();
    test_full_beat();
    test_cnt_zero();
    test_partial();
    test_back_to_back();
    test_random_stall();
    test_reset_mid_beat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
